// File: rtl/correlate_sched.sv
// Pixel sequencer for the correlate stereo datapath: walks a frame in raster order,
// reads census vectors from the row line buffers and strobes them out. Optional macro: CORR_SCHED_STATS_EN.
module correlate_sched #(
   parameter int IMG_W     = 320,
   parameter int IMG_H     = 240,
   parameter int BV_W      = 72,
   parameter int X_W       = 9,
   parameter int Y_W       = 8,
   parameter int ISSUE_GAP = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            abort,
   input  logic            row_ready,
   output logic            row_ack,
   output logic            rd_en,
   output logic [X_W-1:0]  rd_addr,
   input  logic [BV_W-1:0] left_rd_data,
   input  logic [BV_W-1:0] right_rd_data,
   input  logic            corr_ready,
   output logic [BV_W-1:0] left_bitvec,
   output logic [BV_W-1:0] right_bitvec,
   output logic            bitvec_val,
   output logic [X_W-1:0]  pixel_x,
   output logic [Y_W-1:0]  pixel_y,
   output logic            busy,
   output logic            frame_done,
   output logic [31:0]     stall_cycles
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_WAIT_ROW = 3'd1;
   localparam logic [2:0] S_RD       = 3'd2;
   localparam logic [2:0] S_CAP      = 3'd3;
   localparam logic [2:0] S_ISSUE    = 3'd4;
   localparam logic [2:0] S_GAP      = 3'd5;
   localparam logic [2:0] S_ADV      = 3'd6;
   localparam logic [2:0] S_DONE     = 3'd7;

   localparam int              GAP_W    = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((ISSUE_GAP > 0) ? ISSUE_GAP - 1 : 0);
   localparam logic [X_W-1:0]   X_LAST   = X_W'(IMG_W - 1);
   localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(IMG_H - 1);

   logic [2:0]       state, state_nxt;
   logic [X_W-1:0]   x, x_nxt;
   logic [Y_W-1:0]   y, y_nxt;
   logic [GAP_W-1:0] gap_cnt, gap_nxt;
   logic [BV_W-1:0]  left_hold, right_hold;
   logic             start_ok;
   logic             issue_go;

   // Handshake: a vector transfers when ISSUE sees corr_ready=1; bitvec_val is then
   // high for exactly the following cycle and the data/coordinates hold until the next transfer.
   assign start_ok = (state == S_IDLE) && start && !abort;
   assign issue_go = (state == S_ISSUE) && corr_ready && !abort;

   always_comb begin
      state_nxt = state;
      x_nxt     = x;
      y_nxt     = y;
      gap_nxt   = gap_cnt;
      case (state)
         S_IDLE: begin
            if (start_ok) begin
               state_nxt = S_WAIT_ROW;
               y_nxt     = '0;
            end
         end
         S_WAIT_ROW: begin
            if (row_ready) begin
               state_nxt = S_RD;
               x_nxt     = '0;
            end
         end
         S_RD:  state_nxt = S_CAP;
         S_CAP: state_nxt = S_ISSUE;
         S_ISSUE: begin
            if (corr_ready) begin
               gap_nxt   = '0;
               state_nxt = (ISSUE_GAP == 0) ? S_ADV : S_GAP;
            end
         end
         S_GAP: begin
            if (gap_cnt == GAP_LAST) state_nxt = S_ADV;
            else                     gap_nxt   = gap_cnt + GAP_W'(1);
         end
         S_ADV: begin
            if (x < X_LAST) begin
               x_nxt     = x + X_W'(1);
               state_nxt = S_RD;
            end else if (y < Y_LAST) begin
               y_nxt     = y + Y_W'(1);
               state_nxt = S_WAIT_ROW;
            end else begin
               state_nxt = S_DONE;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (abort) state_nxt = S_IDLE;
   end

   // Outputs are registered from the next state so each pulse lines up with its state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         x            <= '0;
         y            <= '0;
         gap_cnt      <= '0;
         left_hold    <= '0;
         right_hold   <= '0;
         row_ack      <= 1'b0;
         rd_en        <= 1'b0;
         rd_addr      <= '0;
         left_bitvec  <= '0;
         right_bitvec <= '0;
         bitvec_val   <= 1'b0;
         pixel_x      <= '0;
         pixel_y      <= '0;
         busy         <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         state      <= state_nxt;
         x          <= x_nxt;
         y          <= y_nxt;
         gap_cnt    <= gap_nxt;
         busy       <= (state_nxt != S_IDLE);
         row_ack    <= (state == S_WAIT_ROW) && row_ready && !abort;
         rd_en      <= (state_nxt == S_RD);
         frame_done <= (state_nxt == S_DONE);
         bitvec_val <= issue_go;
         if (state_nxt == S_RD) rd_addr <= x_nxt;
         if ((state == S_CAP) && !abort) begin
            left_hold  <= left_rd_data;
            right_hold <= right_rd_data;
         end
         if (issue_go) begin
            left_bitvec  <= left_hold;
            right_bitvec <= right_hold;
            pixel_x      <= x;
            pixel_y      <= y;
         end
      end
   end

`ifdef CORR_SCHED_STATS_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
      end else if (start_ok) begin
         stall_q <= '0;
      end else if ((state == S_ISSUE) && !corr_ready && !abort && (stall_q != 32'hFFFF_FFFF)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cycles = stall_q;
`else
   assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_correlate_sched.sv
// Bench for correlate_sched: two instances (ISSUE_GAP=1 and ISSUE_GAP=0) on a 4x2 frame,
// random line-buffer contents, expected strobes queued at frame start and popped by a monitor.
module tb_correlate_sched;

   localparam int W     = 4;
   localparam int H     = 2;
   localparam int BV    = 72;
   localparam int XW    = 9;
   localparam int YW    = 8;
   localparam int EXP_W = 8 + YW + XW + 2 * BV;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_s[2], start_s[2], abort_s[2], row_ready_s[2], corr_ready_s[2];
   logic          row_ack_s[2], rd_en_s[2], bitvec_val_s[2], busy_s[2], frame_done_s[2];
   logic [XW-1:0] rd_addr_s[2], pixel_x_s[2];
   logic [YW-1:0] pixel_y_s[2];
   logic [BV-1:0] l_rd_s[2], r_rd_s[2], l_bv_s[2], r_bv_s[2];
   logic [31:0]   stall_s[2];

   logic [BV-1:0]    tbl_l[2][H][W];
   logic [BV-1:0]    tbl_r[2][H][W];
   logic [EXP_W-1:0] exp_q0[$];
   logic [EXP_W-1:0] exp_q1[$];

   int checks_total = 0;
   int checks_pass  = 0;
   int cyc          = 0;
   int strobe_cnt[2], done_cnt[2], ack_cnt[2], rd_cnt[2], last_cyc[2], rows_claimed[2];

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
      checks_total++;
      if (act === exp) checks_pass++;
      else $display("FAIL %s: got %0h required %0h", name, act, exp);
   endtask

   task automatic mon_strobe(input int g, input logic [BV-1:0] l, input logic [BV-1:0] r,
                             input logic [XW-1:0] px, input logic [YW-1:0] py);
      logic [EXP_W-1:0] e;
      int sp;
      int qsize;
      strobe_cnt[g]++;
      qsize = (g == 0) ? exp_q0.size() : exp_q1.size();
      if (qsize == 0) begin
         checks_total++;
         $display("FAIL unexpected_strobe inst%0d: got (%0d,%0d) required no strobe", g, px, py);
      end else begin
         if (g == 0) e = exp_q0.pop_front();
         else        e = exp_q1.pop_front();
         sp = int'(e[EXP_W-1 -: 8]);
         check($sformatf("pixel_yx inst%0d", g), {py, px}, e[2*BV +: XW+YW]);
         check($sformatf("left_bitvec inst%0d (%0d,%0d)", g, px, py), l, e[BV +: BV]);
         check($sformatf("right_bitvec inst%0d (%0d,%0d)", g, px, py), r, e[0 +: BV]);
         if (sp != 0) check($sformatf("strobe_spacing inst%0d (%0d,%0d)", g, px, py), cyc - last_cyc[g], sp);
      end
      last_cyc[g] = cyc;
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_inst
      int ri, ci;

      correlate_sched #(
         .IMG_W(W), .IMG_H(H), .BV_W(BV), .X_W(XW), .Y_W(YW), .ISSUE_GAP(g == 0 ? 1 : 0)
      ) u_dut (
         .clk(clk), .reset(reset_s[g]), .start(start_s[g]), .abort(abort_s[g]),
         .row_ready(row_ready_s[g]), .row_ack(row_ack_s[g]), .rd_en(rd_en_s[g]),
         .rd_addr(rd_addr_s[g]), .left_rd_data(l_rd_s[g]), .right_rd_data(r_rd_s[g]),
         .corr_ready(corr_ready_s[g]), .left_bitvec(l_bv_s[g]), .right_bitvec(r_bv_s[g]),
         .bitvec_val(bitvec_val_s[g]), .pixel_x(pixel_x_s[g]), .pixel_y(pixel_y_s[g]),
         .busy(busy_s[g]), .frame_done(frame_done_s[g]), .stall_cycles(stall_s[g])
      );

      // Upstream line buffers: the row last claimed by row_ack, 1-cycle read latency.
      always @(posedge clk) begin
         if (!busy_s[g]) rows_claimed[g] = 0;
         if (row_ack_s[g]) rows_claimed[g] = rows_claimed[g] + 1;
         ri = rows_claimed[g] - 1;
         ci = int'(rd_addr_s[g]);
         if (rd_en_s[g] && ri >= 0 && ri < H && ci < W) begin
            l_rd_s[g] <= tbl_l[g][ri][ci];
            r_rd_s[g] <= tbl_r[g][ri][ci];
         end
      end

      always @(negedge clk) begin
         if (!reset_s[g]) begin
            if (row_ack_s[g])    ack_cnt[g]++;
            if (rd_en_s[g])      rd_cnt[g]++;
            if (frame_done_s[g]) done_cnt[g]++;
            if (bitvec_val_s[g]) mon_strobe(g, l_bv_s[g], r_bv_s[g], pixel_x_s[g], pixel_y_s[g]);
         end
      end
   end

   function automatic int get_cnt(input int g, input int which);
      if (which == 0)      return strobe_cnt[g];
      else if (which == 1) return ack_cnt[g];
      else                 return done_cnt[g];
   endfunction

   // which: 0 = strobes, 1 = row_acks, 2 = frame_done pulses
   task automatic wait_evt(input int g, input int which, input int target, input string name);
      int n = 0;
      while (get_cnt(g, which) < target && n < 400) begin
         @(negedge clk); #1;
         n++;
      end
      checks_total++;
      if (get_cnt(g, which) >= target) checks_pass++;
      else $display("FAIL %s: timeout, got count %0d required %0d", name, get_cnt(g, which), target);
   endtask

   task automatic push_frame(input int g, input int npix, input int stall_x, input int stall_n);
      logic [EXP_W-1:0] e;
      int n = 0;
      int sp;
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) begin
            tbl_l[g][y][x] = BV'({$urandom, $urandom, $urandom});
            tbl_r[g][y][x] = BV'({$urandom, $urandom, $urandom});
         end
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) begin
            if (n < npix) begin
               sp = (x == 0) ? 0 : 4 + ((g == 0) ? 1 : 0) + ((y == 0 && x == stall_x) ? stall_n : 0);
               e  = {8'(sp), YW'(y), XW'(x), tbl_l[g][y][x], tbl_r[g][y][x]};
               if (g == 0) exp_q0.push_back(e);
               else        exp_q1.push_back(e);
            end
            n++;
         end
   endtask

   task automatic pulse_start(input int g);
      start_s[g] = 1'b1;
      @(posedge clk); #1;
      start_s[g] = 1'b0;
   endtask

   task automatic check_outputs_zero(input int g, input string name);
      check(name, |{row_ack_s[g], rd_en_s[g], rd_addr_s[g], l_bv_s[g], r_bv_s[g], bitvec_val_s[g],
                    pixel_x_s[g], pixel_y_s[g], busy_s[g], frame_done_s[g], stall_s[g]}, 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bs, ba, br, bd, quiet, exp_stall;
`ifdef CORR_SCHED_STATS_EN
      exp_stall = 3;
`else
      exp_stall = 0;
`endif
      for (int g = 0; g < 2; g++) begin
         reset_s[g] = 1'b1; start_s[g] = 1'b0; abort_s[g] = 1'b0;
         row_ready_s[g] = 1'b1; corr_ready_s[g] = 1'b1;
      end
      repeat (2) @(posedge clk); #1;
      check_outputs_zero(0, "reset_state inst0");
      check_outputs_zero(1, "reset_state inst1");
      reset_s[0] = 1'b0; reset_s[1] = 1'b0;
      repeat (2) @(posedge clk); #1;

      // Plain frame, gap 1
      bs = strobe_cnt[0]; ba = ack_cnt[0]; br = rd_cnt[0]; bd = done_cnt[0];
      push_frame(0, W*H, -1, 0);
      pulse_start(0);
      wait_evt(0, 2, bd + 1, "A_frame_done");
      @(posedge clk); #1;
      check("A_busy_after_done", busy_s[0], 0);
      check("A_strobes", strobe_cnt[0] - bs, 8);
      check("A_row_acks", ack_cnt[0] - ba, 2);
      check("A_reads", rd_cnt[0] - br, 8);
      check("A_done_pulses", done_cnt[0] - bd, 1);
      repeat (3) @(posedge clk); #1;

      // Backpressure at pixel (2,0) for 3 ISSUE cycles
      bs = strobe_cnt[0]; bd = done_cnt[0];
      push_frame(0, W*H, 2, 3);
      pulse_start(0);
      wait_evt(0, 0, bs + 2, "B_strobe_1_0");
      corr_ready_s[0] = 1'b0;
      repeat (7) @(posedge clk); #1;
      corr_ready_s[0] = 1'b1;
      wait_evt(0, 2, bd + 1, "B_frame_done");
      @(posedge clk); #1;
      check("B_strobes", strobe_cnt[0] - bs, 8);
      check("B_stall_cycles", stall_s[0], exp_stall);
      repeat (3) @(posedge clk); #1;

      // Row 1 held back for 10 cycles
      bs = strobe_cnt[0]; ba = ack_cnt[0]; bd = done_cnt[0];
      push_frame(0, W*H, -1, 0);
      pulse_start(0);
      wait_evt(0, 1, ba + 1, "C_row0_ack");
      row_ready_s[0] = 1'b0;
      wait_evt(0, 0, bs + 4, "C_row0_strobes");
      quiet = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (rd_en_s[0] || row_ack_s[0]) quiet++;
      end
      check("C_no_read_in_wait_row", quiet, 0);
      check("C_busy_in_wait_row", busy_s[0], 1);
      row_ready_s[0] = 1'b1;
      wait_evt(0, 2, bd + 1, "C_frame_done");
      check("C_strobes", strobe_cnt[0] - bs, 8);
      check("C_row_acks", ack_cnt[0] - ba, 2);
      repeat (3) @(posedge clk); #1;

      // Abort during the gap after pixel (1,0), then restart
      bs = strobe_cnt[0]; br = rd_cnt[0]; bd = done_cnt[0];
      push_frame(0, 2, -1, 0);
      pulse_start(0);
      wait_evt(0, 0, bs + 2, "D_strobe_1_0");
      abort_s[0] = 1'b1;
      @(posedge clk); #1;
      abort_s[0] = 1'b0;
      check("D_busy_after_abort", busy_s[0], 0);
      check("D_coords_hold", {pixel_y_s[0], pixel_x_s[0]}, {8'd0, 9'd1});
      check("D_left_hold", l_bv_s[0], tbl_l[0][0][1]);
      repeat (20) @(posedge clk); #1;
      check("D_no_strobes_after_abort", strobe_cnt[0] - bs, 2);
      check("D_no_reads_after_abort", rd_cnt[0] - br, 2);
      check("D_no_frame_done", done_cnt[0] - bd, 0);
      bs = strobe_cnt[0];
      push_frame(0, W*H, -1, 0);
      pulse_start(0);
      wait_evt(0, 2, bd + 1, "D_restart_done");
      check("D_restart_strobes", strobe_cnt[0] - bs, 8);

      // Gap 0 instance: mid-frame start ignored, start during DONE ignored
      bs = strobe_cnt[1]; bd = done_cnt[1];
      push_frame(1, W*H, -1, 0);
      pulse_start(1);
      wait_evt(1, 0, bs + 3, "E_strobe_2_0");
      pulse_start(1);
      wait_evt(1, 2, bd + 1, "E_frame_done");
      start_s[1] = 1'b1;
      @(posedge clk); #1;
      start_s[1] = 1'b0;
      quiet = 0;
      repeat (6) begin
         if (busy_s[1]) quiet++;
         @(posedge clk); #1;
      end
      check("E_start_in_done_ignored", quiet, 0);
      check("E_strobes", strobe_cnt[1] - bs, 8);
      check("E_done_pulses", done_cnt[1] - bd, 1);

      // Gap 0 instance: reset mid-frame
      bs = strobe_cnt[1];
      push_frame(1, W*H, -1, 0);
      pulse_start(1);
      wait_evt(1, 0, bs + 3, "F_strobe_2_0");
      reset_s[1] = 1'b1;
      @(posedge clk); #1;
      check_outputs_zero(1, "F_reset_midframe");
      reset_s[1] = 1'b0;
      exp_q1.delete();
      bs = strobe_cnt[1];
      repeat (10) @(posedge clk); #1;
      check("F_idle_after_reset", {busy_s[1], 8'(strobe_cnt[1] - bs)}, 0);

      check("expected_queues_drained", exp_q0.size() + exp_q1.size(), 0);
      $display("%0d/%0d checks passed", checks_pass, checks_total);
      $finish;
   end

endmodule
